// File: rtl/multdiv_iter.sv
// Iterative 32-bit signed multiply (radix-2 Booth) and divide (restoring, on magnitudes), one bit per cycle, ready pulse 33 edges after start.
// Optional MULTDIV_EARLY_DONE_EN: a zero multiply operand or zero divisor finishes on edge 1 instead.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   hi_q;     // Booth accumulator or partial remainder, one guard bit
  logic [WIDTH-1:0] lo_q;     // multiplier or dividend/quotient shift register
  logic             q1_q;
  logic [WIDTH-1:0] opd_q;    // multiplicand, or divisor magnitude
  logic             neg_q;
  logic             zero_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;

  logic             start;
  logic             early;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_trial;

  // Both controls together is not a start; the running operation carries on.
  assign start = ctrl_MULT ^ ctrl_DIV;
  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_EARLY_DONE_EN
  assign early = ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                           : (data_operandB == '0);
`else
  assign early = 1'b0;
`endif

  // The guard bit keeps acc +/- multiplicand exact when the multiplicand is -2^(W-1).
  always_comb begin
    mcand_ext = {opd_q[WIDTH-1], opd_q};
    case ({lo_q[0], q1_q})
      2'b01:   booth_sum = hi_q + mcand_ext;
      2'b10:   booth_sum = hi_q - mcand_ext;
      default: booth_sum = hi_q;
    endcase
  end

  assign rem_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, opd_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      q1_q     <= 1'b0;
      opd_q    <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        // Early completion parks the counter at its final value so edge 1 finishes.
        cnt_q <= early ? LAST : '0;
        hi_q  <= '0;
        q1_q  <= 1'b0;
        if (ctrl_MULT) begin
          state_q <= MUL;
          lo_q    <= early ? '0 : data_operandB;
          opd_q   <= data_operandA;
          neg_q   <= 1'b0;
          zero_q  <= 1'b0;
        end else begin
          state_q <= DIV;
          lo_q    <= mag_a;
          opd_q   <= mag_b;
          neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          zero_q  <= (data_operandB == '0);
        end
      end else begin
        case (state_q)
          MUL: begin
            if (cnt_q == LAST) begin
              state_q  <= DONE;
              rdy_q    <= 1'b1;
              result_q <= lo_q;
              exc_q    <= (hi_q[WIDTH-1:0] != {WIDTH{lo_q[WIDTH-1]}});
            end else begin
              cnt_q <= cnt_q + CW'(1);
              hi_q  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
              lo_q  <= {booth_sum[0], lo_q[WIDTH-1:1]};
              q1_q  <= lo_q[0];
            end
          end
          DIV: begin
            if (cnt_q == LAST) begin
              state_q <= DONE;
              rdy_q   <= 1'b1;
              if (zero_q) begin
                result_q <= '0;
                exc_q    <= 1'b1;
              end else if (neg_q) begin
                result_q <= -lo_q;
                exc_q    <= 1'b0;
              end else begin
                // A positive quotient with the top bit set is only 2^31 / 1 from -2^31 / -1.
                result_q <= lo_q;
                exc_q    <= lo_q[WIDTH-1];
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
              if (rem_trial[WIDTH]) begin
                hi_q <= rem_shift;
                lo_q <= {lo_q[WIDTH-2:0], 1'b0};
              end else begin
                hi_q <= rem_trial;
                lo_q <= {lo_q[WIDTH-2:0], 1'b1};
              end
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Bench for multdiv_iter: cycle-level reference model with per-cycle compare, directed literal cases, randomized starts/aborts.
module tb_multdiv_iter;
  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

`ifdef MULTDIV_EARLY_DONE_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = 33;
`endif

  multdiv_iter #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: what the result and exception must be.
  function automatic void ref_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  function automatic int ref_lat(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_EARLY_DONE_EN
    if (is_mul ? (a == 0 || b == 0) : (b == 0)) return 1;
`endif
    return 33;
  endfunction

  // Cycle model: countdown to completion, results visible from the ready cycle on.
  int          remaining = -1;
  logic [31:0] pend_res, m_res;
  logic        pend_exc, m_exc, m_rdy;
  initial begin m_res = 0; m_exc = 0; m_rdy = 0; end

  always @(posedge clock) begin
    m_rdy = 1'b0;
    if (reset) begin
      remaining = -1;
      m_res = 32'd0;
      m_exc = 1'b0;
    end else if (ctrl_MULT ^ ctrl_DIV) begin
      ref_op(ctrl_MULT, data_operandA, data_operandB, pend_res, pend_exc);
      remaining = ref_lat(ctrl_MULT, data_operandA, data_operandB);
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        m_rdy = 1'b1;
        m_res = pend_res;
        m_exc = pend_exc;
        remaining = -1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc rdy", {31'd0, data_resultRDY}, {31'd0, m_rdy});
      check("cyc result", data_result, m_res);
      check("cyc exc", {31'd0, data_exception}, {31'd0, m_exc});
    end
  end

  // Called at #1 after an edge; the next edge is the start edge.
  task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV  = d;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom();
    data_operandB = $urandom();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic run_op(input string name, input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input bit ee, input int elat);
    int n;
    bit seen;
    pulse(is_mul, !is_mul, a, b);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clock); #1;
      n++;
      seen = data_resultRDY;
    end
    check({name, " latency"}, 32'(n), 32'(elat));
    check({name, " result"}, data_result, er);
    check({name, " exc"}, {31'd0, data_exception}, {31'd0, ee});
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hffff_ffff;
      3: return 32'($urandom_range(0, 20)) - 32'd10;
      4: return 32'($urandom_range(0, 65535));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int cnt, at, k;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    step(3);
    chk_en = 1'b1;
    check("reset result", data_result, 32'd0);
    check("reset exc", {31'd0, data_exception}, 32'd0);
    check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;
    step(2);

    run_op("mul 7*-6", 1, 32'd7, -32'd6, -32'd42, 0, 33);
    run_op("mul 2^16*2^16", 1, 32'd65536, 32'd65536, 32'd0, 1, 33);
    run_op("mul -2^31*1", 1, 32'h8000_0000, 32'd1, 32'h8000_0000, 0, 33);
    run_op("div -7/2", 0, -32'd7, 32'd2, -32'd3, 0, 33);
    run_op("div max/-1", 0, 32'h7fff_ffff, 32'hffff_ffff, 32'h8000_0001, 0, 33);
    run_op("div -2^31/-1", 0, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1, 33);
    run_op("div 5/0", 0, 32'd5, 32'd0, 32'd0, 1, LAT_ZERO);
    step(3);

    // Abort: a divide started five cycles into a multiply is the only one to complete.
    pulse(1, 0, 32'd3, 32'd3);
    step(4);
    pulse(0, 1, 32'd100, 32'd7);
    cnt = 0;
    at = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        cnt++;
        at = n;
        check("abort result", data_result, 32'd14);
      end
    end
    check("abort pulses", 32'(cnt), 32'd1);
    check("abort latency", 32'(at), 32'd33);

    // Reset mid-multiply clears outputs and suppresses the ready pulse.
    pulse(1, 0, 32'd12345, 32'd678);
    step(10);
    reset = 1'b1;
    step(1);
    check("midreset result", data_result, 32'd0);
    check("midreset exc", {31'd0, data_exception}, 32'd0);
    check("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) cnt++;
    end
    check("midreset no rdy", 32'(cnt), 32'd0);
    run_op("mul after reset", 1, 32'd12345, 32'd678, 32'd8369910, 0, 33);

    // Both controls together is not a start.
    pulse(1, 1, 32'd9, 32'd9);
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) cnt++;
    end
    check("both high no rdy", 32'(cnt), 32'd0);
    check("both high result held", data_result, 32'd8369910);

    // Random starts, aborts, restarts in DONE and ignored double pulses.
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 12);
      if (k == 0) pulse(1, 1, rnd_opnd(), rnd_opnd());
      else pulse(k < 7, k >= 7, rnd_opnd(), rnd_opnd());
      if ($urandom_range(0, 3) == 0) step($urandom_range(0, 32));
      else step($urandom_range(32, 36));
    end
    step(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
